// File: rtl/pds_router_if.sv
// Packet-stream bundle between the upstream source, the router and the port monitors.
// master: the packet source / port consumers; slave: the router.
interface pds_router_if #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16
);
  logic [15:0]             data_ip;
  logic                    valid_up;
  logic                    ready_up;
  logic [16*NUM_PORTS-1:0] data_op;
  logic [NUM_PORTS-1:0]    valid_op;
  logic [NUM_PORTS-1:0]    ready_op;
  logic [CNT_W-1:0]        accept_cnt;
  logic [CNT_W-1:0]        drop_cnt;

  modport master (
    output data_ip, valid_up, ready_op,
    input  ready_up, data_op, valid_op, accept_cnt, drop_cnt
  );

  modport slave (
    input  data_ip, valid_up, ready_op,
    output ready_up, data_op, valid_op, accept_cnt, drop_cnt
  );
endinterface

// File: rtl/pds_router.sv
// Packet switch core: decodes the target nibble of each input word and queues it
// in a per-port FIFO whose head is offered to that port's monitor via valid/ready.
module pds_router #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          reset,
  pds_router_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [3:0]              tgt;
  logic                    legal;
  logic                    acc;
  logic                    ready_w;
  logic [NUM_PORTS-1:0]    full_v;
  logic [NUM_PORTS-1:0]    valid_v;
  logic [16*NUM_PORTS-1:0] data_v;
  logic [CNT_W-1:0]        accept_q;
  logic [CNT_W-1:0]        drop_q;

  assign tgt     = bus.data_ip[11:8];
  assign legal   = ({1'b0, tgt} < 5'(NUM_PORTS));
  // Any full FIFO stalls the whole input stream, even for other targets.
  assign ready_w = ~|full_v;
  assign acc     = bus.valid_up && ready_w;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   last_q;
    logic          push;
    logic          pop;

    assign push = acc && legal && (tgt == 4'(p));
    assign pop  = (count != '0) && bus.ready_op[p];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.data_ip;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        last_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          last_q <= mem[rd_ptr];
        end
        if (push && !pop)      count <= count + CNT_ONE;
        else if (pop && !push) count <= count - CNT_ONE;
      end
    end

    assign full_v[p]           = (count == CNT_FULL);
    assign valid_v[p]          = (count != '0);
    // An empty port keeps showing the word it last handed out.
    assign data_v[16*p +: 16]  = (count == '0) ? last_q : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      accept_q <= '0;
      drop_q   <= '0;
    end else if (acc) begin
      accept_q <= sat_inc(accept_q);
      if (!legal) drop_q <= sat_inc(drop_q);
    end
  end

  assign bus.ready_up   = ready_w;
  assign bus.valid_op   = valid_v;
  assign bus.data_op    = data_v;
  assign bus.accept_cnt = accept_q;
  assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_pds_router.sv
// Directed bench for pds_router: a 16-bit-counter instance for routing/FIFO behaviour
// and a 4-bit-counter instance for counter saturation.
module tb_pds_router;
  logic clk = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pds_router_if #(.NUM_PORTS(4), .CNT_W(16)) bus0 ();
  pds_router_if #(.NUM_PORTS(4), .CNT_W(4))  bus1 ();

  pds_router #(.NUM_PORTS(4), .DEPTH(4), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset0), .bus(bus0)
  );
  pds_router #(.NUM_PORTS(4), .DEPTH(4), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset1), .bus(bus1)
  );

  task automatic do_reset0();
    reset0 = 1'b1;
    bus0.valid_up = 1'b0;
    @(posedge clk); #1;
    reset0 = 1'b0;
  endtask

  task automatic send0(input logic [15:0] w);
    bus0.data_ip  = w;
    bus0.valid_up = 1'b1;
    @(posedge clk); #1;
    bus0.valid_up = 1'b0;
  endtask

  task automatic test_reset();
    do_reset0();
    tests_run++;
    if (bus0.valid_op !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_valid_op: got %b expected 0000", bus0.valid_op);
    end
    tests_run++;
    if (bus0.data_op !== 64'h0) begin
      tests_failed++; $display("FAIL reset_data_op: got %h expected 0", bus0.data_op);
    end
    tests_run++;
    if (bus0.ready_up !== 1'b1) begin
      tests_failed++; $display("FAIL reset_ready_up: got %b expected 1", bus0.ready_up);
    end
    tests_run++;
    if (bus0.accept_cnt !== 16'd0 || bus0.drop_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: got acc=%0d drop=%0d expected 0/0", bus0.accept_cnt, bus0.drop_cnt);
    end
  endtask

  task automatic test_single();
    do_reset0();
    bus0.ready_op = 4'hF;
    send0(16'h12A5);
    tests_run++;
    if (bus0.valid_op !== 4'b0100) begin
      tests_failed++; $display("FAIL single_valid: got %b expected 0100", bus0.valid_op);
    end
    tests_run++;
    if (bus0.data_op[47:32] !== 16'h12A5) begin
      tests_failed++; $display("FAIL single_data: got %h expected 12a5", bus0.data_op[47:32]);
    end
    tests_run++;
    if (bus0.accept_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL single_accept_cnt: got %0d expected 1", bus0.accept_cnt);
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus0.valid_op !== 4'b0000) begin
      tests_failed++; $display("FAIL single_one_cycle: got %b expected 0000", bus0.valid_op);
    end
  endtask

  task automatic test_full();
    do_reset0();
    bus0.ready_op = 4'h0;
    for (int k = 0; k < 4; k++) begin
      send0(16'(k));
      tests_run++;
      if (bus0.ready_up !== (k == 3 ? 1'b0 : 1'b1)) begin
        tests_failed++;
        $display("FAIL full_ready_up_%0d: got %b expected %b", k, bus0.ready_up, (k == 3 ? 1'b0 : 1'b1));
      end
    end
    @(posedge clk); #1;
    tests_run++;
    if (bus0.data_op[15:0] !== 16'h0000 || bus0.valid_op[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_hold: got v=%b d=%h expected v=1 d=0000", bus0.valid_op[0], bus0.data_op[15:0]);
    end
    bus0.ready_op = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (bus0.valid_op[0] !== 1'b1 || bus0.data_op[15:0] !== 16'(k)) begin
        tests_failed++;
        $display("FAIL full_pop_%0d: got v=%b d=%h expected v=1 d=%h", k, bus0.valid_op[0], bus0.data_op[15:0], 16'(k));
      end
      @(posedge clk); #1;
      if (k == 0) begin
        tests_run++;
        if (bus0.ready_up !== 1'b1) begin
          tests_failed++; $display("FAIL full_ready_return: got %b expected 1", bus0.ready_up);
        end
      end
    end
    tests_run++;
    if (bus0.valid_op[0] !== 1'b0) begin
      tests_failed++; $display("FAIL full_drained: got %b expected 0", bus0.valid_op[0]);
    end
    bus0.ready_op = 4'h0;
  endtask

  task automatic test_drop();
    do_reset0();
    bus0.ready_op = 4'h0;
    send0(16'h0500);
    send0(16'h0F00);
    tests_run++;
    if (bus0.valid_op !== 4'b0000) begin
      tests_failed++; $display("FAIL drop_valid: got %b expected 0000", bus0.valid_op);
    end
    tests_run++;
    if (bus0.drop_cnt !== 16'd2 || bus0.accept_cnt !== 16'd2) begin
      tests_failed++;
      $display("FAIL drop_counts: got acc=%0d drop=%0d expected 2/2", bus0.accept_cnt, bus0.drop_cnt);
    end
    send0(16'h3400);
    tests_run++;
    if (bus0.drop_cnt !== 16'd3 || bus0.valid_op !== 4'b0000) begin
      tests_failed++;
      $display("FAIL drop_target4: got drop=%0d v=%b expected 3 0000", bus0.drop_cnt, bus0.valid_op);
    end
  endtask

  task automatic test_back_to_back();
    do_reset0();
    bus0.ready_op = 4'h0;
    send0(16'h2100);
    send0(16'h2101);
    bus0.ready_op = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      bus0.data_ip  = 16'h2102 + 16'(i);
      bus0.valid_up = 1'b1;
      tests_run++;
      if (bus0.valid_op[1] !== 1'b1 || bus0.data_op[31:16] !== 16'h2100 + 16'(i)) begin
        tests_failed++;
        $display("FAIL b2b_head_%0d: got v=%b d=%h expected v=1 d=%h", i, bus0.valid_op[1], bus0.data_op[31:16], 16'h2100 + 16'(i));
      end
      @(posedge clk); #1;
    end
    bus0.valid_up = 1'b0;
    for (int i = 6; i < 8; i++) begin
      tests_run++;
      if (bus0.valid_op[1] !== 1'b1 || bus0.data_op[31:16] !== 16'h2100 + 16'(i)) begin
        tests_failed++;
        $display("FAIL b2b_drain_%0d: got v=%b d=%h expected v=1 d=%h", i, bus0.valid_op[1], bus0.data_op[31:16], 16'h2100 + 16'(i));
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (bus0.valid_op[1] !== 1'b0 || bus0.accept_cnt !== 16'd8) begin
      tests_failed++;
      $display("FAIL b2b_end: got v=%b acc=%0d expected v=0 acc=8", bus0.valid_op[1], bus0.accept_cnt);
    end
    bus0.ready_op = 4'h0;
  endtask

  task automatic test_mid_reset();
    do_reset0();
    bus0.ready_op = 4'h0;
    send0(16'h0300);
    send0(16'h0301);
    send0(16'h0302);
    tests_run++;
    if (bus0.valid_op !== 4'b1000) begin
      tests_failed++; $display("FAIL midrst_pre: got %b expected 1000", bus0.valid_op);
    end
    reset0 = 1'b1;
    bus0.data_ip  = 16'h0333;
    bus0.valid_up = 1'b1;
    @(posedge clk); #1;
    reset0 = 1'b0;
    bus0.valid_up = 1'b0;
    tests_run++;
    if (bus0.valid_op !== 4'b0000 || bus0.ready_up !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_state: got v=%b rdy=%b expected 0000 1", bus0.valid_op, bus0.ready_up);
    end
    tests_run++;
    if (bus0.accept_cnt !== 16'd0 || bus0.drop_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_counters: got acc=%0d drop=%0d expected 0/0", bus0.accept_cnt, bus0.drop_cnt);
    end
    bus0.ready_op = 4'hF;
    send0(16'h03C3);
    tests_run++;
    if (bus0.valid_op !== 4'b1000 || bus0.data_op[63:48] !== 16'h03C3 || bus0.accept_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL midrst_after: got v=%b d=%h acc=%0d expected 1000 03c3 1", bus0.valid_op, bus0.data_op[63:48], bus0.accept_cnt);
    end
    bus0.ready_op = 4'h0;
  endtask

  task automatic test_saturation();
    reset1 = 1'b1;
    bus1.valid_up = 1'b0;
    bus1.ready_op = 4'h0;
    @(posedge clk); #1;
    reset1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus1.data_ip  = 16'h0F00 + 16'(i);
      bus1.valid_up = 1'b1;
      @(posedge clk); #1;
      if (i == 14) begin
        tests_run++;
        if (bus1.drop_cnt !== 4'd15 || bus1.accept_cnt !== 4'd15) begin
          tests_failed++;
          $display("FAIL sat_reach: got acc=%0d drop=%0d expected 15/15", bus1.accept_cnt, bus1.drop_cnt);
        end
      end
    end
    bus1.valid_up = 1'b0;
    tests_run++;
    if (bus1.drop_cnt !== 4'd15 || bus1.accept_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_hold: got acc=%0d drop=%0d expected 15/15", bus1.accept_cnt, bus1.drop_cnt);
    end
    tests_run++;
    if (bus1.valid_op !== 4'b0000 || bus1.ready_up !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_no_write: got v=%b rdy=%b expected 0000 1", bus1.valid_op, bus1.ready_up);
    end
  endtask

  initial begin
    bus0.data_ip  = 16'h0;
    bus0.valid_up = 1'b0;
    bus0.ready_op = 4'h0;
    bus1.data_ip  = 16'h0;
    bus1.valid_up = 1'b0;
    bus1.ready_op = 4'h0;
    test_reset();
    test_single();
    test_full();
    test_drop();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pds_router.md
Name: pds_router

Overview:
- Packet switch core of the pds block; the consumer of the 16-bit input packet stream (data_ip / valid_up).
- Each input word is one packet: {source[15:12], target[11:8], data[7:0]}.
- The router decodes the target nibble and buffers the packet in a per-port FIFO.
- Each output port presents its FIFO head with a valid/ready handshake toward the port monitors.

Parameters:
- NUM_PORTS, 4, number of output ports; legal range 1..16.
- DEPTH, 4, entries per port FIFO; power of 2, range 2..16.
- CNT_W, 16, width of the accept and drop counters.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- data_ip  input  16  input packet {source, target, data}.
- valid_up  input  1  data_ip valid.
- ready_up  output  1  router can accept a packet this cycle.
- data_op  output  16*NUM_PORTS  port p head packet in bits [16p+15:16p], unmodified packet word.
- valid_op  output  NUM_PORTS  port p FIFO non-empty.
- ready_op  input  NUM_PORTS  port p consumer accepts head.
- accept_cnt  output  CNT_W  packets accepted, saturating.
- drop_cnt  output  CNT_W  packets dropped for illegal target, saturating.

Behaviour:
- Reset: on the clk edge with reset=1, all FIFOs are emptied (pointers and counts = 0).
  - valid_op=0, data_op=0, accept_cnt=0, drop_cnt=0.
  - ready_up=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered packets; no handshake completes on the reset edge.
- ready_up is combinational from state only: 1 iff no port FIFO is full. It never depends on valid_up or data_ip.
- Accept: happens on a clk edge where valid_up && ready_up.
  - data_ip is sampled at that edge; data_ip is don't-care when valid_up=0.
  - target < NUM_PORTS: the word is pushed into FIFO[target] and accept_cnt increments.
  - target >= NUM_PORTS: nothing is written; drop_cnt and accept_cnt both increment.
- Latency: a packet accepted at edge N into an empty FIFO shows valid_op[p]=1 with data_op[p]=packet after edge N. There is no same-cycle bypass.
- Output handshake, per port:
  - valid_op[p] = FIFO[p] non-empty; data_op[p] = FIFO[p] head.
  - Pop on an edge where valid_op[p] && ready_op[p].
  - data_op[p] holds stable while valid_op[p]=1 and ready_op[p]=0.
  - data_op[p] when empty: holds the last popped value; the bench must not check it.
- Simultaneous push and pop on the same port: both take effect; count is unchanged; FIFO order is preserved.
- Full: a FIFO reaching DEPTH drops ready_up for all ports (head-of-line blocking is intentional).
  - Pops on the full port free it; ready_up returns the cycle after the pop edge.
- Ordering: strict FIFO per port. No ordering guarantee across ports.
- Counters: each increments by 1 per qualifying accept and saturates at 2^CNT_W-1; no wrap.
- Pointers: log2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
  - Occupancy is a log2(DEPTH)+1-bit count.
  - Full = count==DEPTH; empty = count==0.
- source and data fields are not interpreted; source==target is legal.

Test Plan:
1. Reset, then ready_op=all 1s; send 0x1_2_A5 (source 1, target 2, data 0xA5) -> valid_op=4'b0100 for exactly one cycle, starting the cycle after accept; data_op[47:32]=0x12A5; accept_cnt=1.
2. ready_op=0; send 4 packets to target 0 with data 0x00..0x03 -> ready_up=0 after the 4th accept. Raise ready_op[0] -> data pops in order 0x00,0x01,0x02,0x03; ready_up=1 the cycle after the first pop.
3. NUM_PORTS=4; send target 5, then target 15 -> no valid_op rises; drop_cnt=2; accept_cnt=2.
4. FIFO[1] holds 2 entries with ready_op[1]=1; push a target-1 packet each cycle for 6 cycles -> count stays 2, no loss, output sequence equals input sequence.
5. Assert reset for one cycle while 3 packets are buffered in port 3 -> next cycle: valid_op=0, counters 0, ready_up=1; a following packet is delivered normally.
6. CNT_W=4; send 20 illegal-target packets -> drop_cnt saturates at 15; accept_cnt=15.
